lab3_sweep_ctrl: RTL
====================

Name: lab3_sweep_ctrl

Overview:
- Self-test sequencer for the lab3 combinational logic block (inputs a/b/c, outputs x/y).
- On start, drives all 8 input vectors {a,b,c} = 0..7 in order and holds each for DWELL cycles.
- Captures {y,x} for each vector into a 16-bit result word and compares it against a golden word.
- Reports pass/fail and mismatch count; sits between board switches/buttons and the lab3 instance.

Parameters:
- DWELL, 4, cycles each vector is held; legal range >=1.
- GOLDEN, 16'hE441, expected result word. Bits [2v+1:2v] = {y,x} for vector v.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a sweep
- abort  in  1  cancel the sweep in progress
- x_in  in  1  x output of lab3 under test
- y_in  in  1  y output of lab3 under test
- a_out  out  1  drive to lab3 input a (vector bit 2)
- b_out  out  1  drive to lab3 input b (vector bit 1)
- c_out  out  1  drive to lab3 input c (vector bit 0)
- busy  out  1  high while in DRIVE or CHECK
- done  out  1  one-cycle pulse when the sweep completes
- pass  out  1  result == GOLDEN; valid from done until the next start
- result  out  16  captured {y,x} pairs
- err_cnt  out  4  number of vectors whose {y,x} differs from the GOLDEN slice (0..8)

Behaviour:
- Reset (async): state=IDLE, v=0, dwell count=0, a/b/c=0, busy=0, done=0, pass=0, result=0, err_cnt=0. Applies immediately, including mid-sweep.
- All outputs are registered. a/b/c always equal the current vector v.
- IDLE:
  - start=1 and abort=0 at an edge: go to DRIVE, v=0, count=0, result=0, err_cnt=0, pass=0.
  - start=1 and abort=1 together: abort wins; stay in IDLE.
- DRIVE:
  - Count advances each cycle.
  - At the edge where count==DWELL-1: result[2v+:2] <= {y_in,x_in}; err_cnt increments if that pair differs from GOLDEN[2v+:2]; count <= 0.
  - After that capture: if v==7, go to CHECK; otherwise v <= v+1.
  - With DWELL=1 the count stays at 0 and a capture happens every cycle.
- CHECK:
  - One cycle only.
  - At its ending edge: pass <= (result==GOLDEN), done <= 1, go to IDLE, v <= 0 (a/b/c return to 000).
- done clears on the following edge.
- Timing: with start sampled at edge E0, capture edges are E(DWELL)..E(8*DWELL), CHECK occupies the next cycle, and done is high after edge E(8*DWELL+1) for exactly one cycle.
- Sampling x/y at the end of the dwell gives the combinational DUT at least one full cycle to settle after a/b/c change.
- abort=1 in DRIVE or CHECK: go to IDLE next edge; busy=0; a/b/c=000; no done pulse; pass=0. result/err_cnt keep any partial captures.
- start while busy: ignored.
- result, pass and err_cnt hold after done until the next accepted start.
- err_cnt saturation is unnecessary; its maximum value is 8.

Decomposition:
- Package lab3_pkg:
  - state enum {IDLE, DRIVE, CHECK}
  - NUM_VEC=8
  - GOLDEN_DEFAULT=16'hE441
  - function lab3_ref(v) returning {y,x}, where x = ~(c ^ (a|b)) and y = a&b; shared with the bench
- Sub-module lab3_dwell_timer:
  - parameter DWELL
  - inputs clk, rst, clr, en
  - output tick, high when count==DWELL-1
  - counter width $clog2(DWELL), minimum 1

Test Plan:
- Fault-free lab3 connected, DWELL=4, single start pulse -> a/b/c step 000..111, each held 4 cycles; done pulses after edge E33; result=16'hE441, pass=1, err_cnt=0; busy high for exactly 33 cycles.
- y_in forced to 0 -> result=16'h4441, err_cnt=2, pass=0, done still after E33.
- abort asserted in the 10th DRIVE cycle -> busy=0 and a/b/c=000 on the next edge; no done pulse; result bits [3:0]=2'b01,2'b00 retained. A later start runs the full sweep and gives pass=1.
- start pulsed repeatedly during DRIVE -> no restart; v sequence and done timing unchanged. start and abort together in IDLE -> busy stays 0.
- rst asserted asynchronously between clock edges while v=5 -> all outputs are 0 before the next edge. After release, start -> clean sweep, pass=1.
- DWELL=1 -> one capture per cycle, done after edge E9, result=16'hE441, pass=1.

Source files
------------

// File: rtl/lab3_pkg.sv
// Shared definitions for the lab3 self-test sequencer.
//   state_t        : sequencer states
//   NUM_VEC        : number of input vectors swept ({a,b,c} = 0..7)
//   GOLDEN_DEFAULT : expected {y,x} word for a fault-free lab3 block
//   lab3_ref()     : reference model of lab3, returns {y,x} for vector {a,b,c}
package lab3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int          NUM_VEC        = 8;
    localparam logic [15:0] GOLDEN_DEFAULT = 16'hE441;

    function automatic logic [1:0] lab3_ref(input logic [2:0] v);
        logic a, b, c, x, y;
        a = v[2];
        b = v[1];
        c = v[0];
        x = ~(c ^ (a | b));
        y = a & b;
        return {y, x};
    endfunction

endpackage

// File: rtl/lab3_dwell_timer.sv
// Dwell timer for the lab3 sweep sequencer.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   clr  : synchronous clear of the count (dominates en)
//   en   : advance the count; wraps to 0 after DWELL-1
//   tick : high while count == DWELL-1 (always high when DWELL == 1)
module lab3_dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] count_q, count_d;

    assign tick = (count_q == CW'(DWELL - 1));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lab3_sweep_ctrl.sv
// Self-test sequencer for the lab3 combinational block.
// Sweeps {a,b,c} through 0..7, holding each vector DWELL cycles, captures
// {y,x} at the end of each dwell and compares the collected word to GOLDEN.
//   clk, rst        : system clock, asynchronous active-high reset
//   start, abort    : begin a sweep / cancel the sweep in progress
//   x_in, y_in      : outputs of the lab3 block under test
//   a_out..c_out    : lab3 inputs (vector bits 2..0)
//   busy            : sweep in progress (DRIVE or CHECK)
//   done            : one-cycle pulse when the sweep completes
//   pass            : result == GOLDEN, valid from done until next start
//   result, err_cnt : captured {y,x} pairs, number of mismatching vectors
//
// state | meaning
// IDLE  | waiting for start; outputs hold last sweep
// DRIVE | driving vector v, capture at end of each dwell
// CHECK | one cycle; compare result and pulse done
module lab3_sweep_ctrl
    import lab3_pkg::*;
#(
    parameter int          DWELL  = 4,
    parameter logic [15:0] GOLDEN = GOLDEN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        x_in,
    input  logic        y_in,
    output logic        a_out,
    output logic        b_out,
    output logic        c_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] result,
    output logic [3:0]  err_cnt
);

    state_t      state_q, state_d;
    logic [2:0]  v_q, v_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  err_q, err_d;
    logic        pass_q, pass_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        tick;
    logic [1:0]  pair;
    logic [3:0]  slice_idx;

    // Count only runs in DRIVE, so every dwell starts from zero.
    lab3_dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q != DRIVE),
        .en   (state_q == DRIVE),
        .tick (tick)
    );

    assign pair      = {y_in, x_in};
    assign slice_idx = {v_q, 1'b0};

    always_comb begin
        state_d  = state_q;
        v_d      = v_q;
        result_d = result_q;
        err_d    = err_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // abort dominates a simultaneous start
                if (start && !abort) begin
                    state_d  = DRIVE;
                    v_d      = '0;
                    result_d = '0;
                    err_d    = '0;
                    pass_d   = 1'b0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    v_d     = '0;
                    pass_d  = 1'b0;
                end else if (tick) begin
                    result_d[slice_idx +: 2] = pair;
                    if (pair != GOLDEN[slice_idx +: 2]) begin
                        err_d = err_q + 4'd1;
                    end
                    if (v_q == 3'(NUM_VEC - 1)) begin
                        state_d = CHECK;
                    end else begin
                        v_d = v_q + 3'd1;
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                v_d     = '0;
                if (abort) begin
                    pass_d = 1'b0;
                end else begin
                    pass_d = (result_q == GOLDEN);
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                v_d     = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            v_q      <= '0;
            result_q <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            result_q <= result_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign a_out   = v_q[2];
    assign b_out   = v_q[1];
    assign c_out   = v_q[0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign result  = result_q;
    assign err_cnt = err_q;

endmodule
